ball_collision_detect: RTL and testbench

Per-pixel collision detector feeding `ball_logic`. Watches the raster scan, compares each active pixel against a per-frame snapshot of the ball box, and flags any pixel where the ball overlaps a drawn obstacle (wall, brick, paddle). It drives the collision pulses and side flags that `ball_logic` latches through the frame. It also captures the first contact point of each frame for brick removal, and keeps a saturating hit count.

---
 rtl/ball_collision_detect_pkg.sv | 18 +
 rtl/ball_collision_detect_if.sv | 40 ++++
 rtl/ball_collision_detect_box_match.sv | 39 +++
 rtl/ball_collision_detect.sv | 102 ++++++++++
 tb/tb_ball_collision_detect.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/ball_collision_detect_pkg.sv
// Shared screen geometry, coordinate widths and collision-detector types.
// Used by ball_logic, the renderer and the collision detector.
package ball_collision_detect_pkg;

    localparam int unsigned X_W = 10;
    localparam int unsigned Y_W = 9;

    localparam logic [X_W-1:0] H_ACTIVE = 10'd640;
    localparam logic [Y_W-1:0] V_ACTIVE = 9'd480;

    localparam int unsigned BALL_SIZE_DEF = 4;

    typedef enum logic {
        UNARMED = 1'b0,
        ARMED   = 1'b1
    } det_state_t;

endpackage

// File: rtl/ball_collision_detect_if.sv
// Raster/ball inputs and collision results between the scan logic and the detector.
interface ball_collision_detect_if
    import ball_collision_detect_pkg::*;
#(
    parameter int unsigned HIT_CNT_W = 4
);
    logic                 frame_pulse;
    logic [X_W-1:0]       ball_x;
    logic [Y_W-1:0]       ball_y;
    logic [X_W-1:0]       hpos;
    logic [Y_W-1:0]       vpos;
    logic                 active;
    logic                 obstacle;

    logic                 ball_pixel;
    logic                 collision;
    logic                 ball_top_col;
    logic                 ball_bottom_col;
    logic                 ball_left_col;
    logic                 ball_right_col;
    logic                 first_hit_valid;
    logic [X_W-1:0]       first_hit_x;
    logic [Y_W-1:0]       first_hit_y;
    logic [HIT_CNT_W-1:0] hit_count;

    modport master (
        output frame_pulse, ball_x, ball_y, hpos, vpos, active, obstacle,
        input  ball_pixel, collision, ball_top_col, ball_bottom_col,
               ball_left_col, ball_right_col, first_hit_valid,
               first_hit_x, first_hit_y, hit_count
    );

    modport slave (
        input  frame_pulse, ball_x, ball_y, hpos, vpos, active, obstacle,
        output ball_pixel, collision, ball_top_col, ball_bottom_col,
               ball_left_col, ball_right_col, first_hit_valid,
               first_hit_x, first_hit_y, hit_count
    );

endinterface

// File: rtl/ball_collision_detect_box_match.sv
// Combinational in-box test and edge compares of the scan position against the ball snapshot.
module ball_box_match
    import ball_collision_detect_pkg::*;
#(
    parameter int unsigned BALL_SIZE = BALL_SIZE_DEF
) (
    input  logic [X_W-1:0] snap_x,
    input  logic [Y_W-1:0] snap_y,
    input  logic [X_W-1:0] hpos,
    input  logic [Y_W-1:0] vpos,
    input  logic           active,
    output logic           in_box,
    output logic           edge_top,
    output logic           edge_bottom,
    output logic           edge_left,
    output logic           edge_right
);

    logic [X_W:0] x_end;
    logic [Y_W:0] y_end;
    logic         on_screen;

    // One extra bit keeps boxes hanging off the right/bottom edge from wrapping to 0.
    assign x_end = {1'b0, snap_x} + (X_W+1)'(BALL_SIZE) - (X_W+1)'(1);
    assign y_end = {1'b0, snap_y} + (Y_W+1)'(BALL_SIZE) - (Y_W+1)'(1);

    assign on_screen = active && (hpos < H_ACTIVE) && (vpos < V_ACTIVE);

    always_comb begin
        in_box = on_screen
              && (hpos >= snap_x) && ({1'b0, hpos} <= x_end)
              && (vpos >= snap_y) && ({1'b0, vpos} <= y_end);
        edge_top    = in_box && (vpos == snap_y);
        edge_bottom = in_box && ({1'b0, vpos} == y_end);
        edge_left   = in_box && (hpos == snap_x);
        edge_right  = in_box && ({1'b0, hpos} == x_end);
    end

endmodule

// File: rtl/ball_collision_detect.sv
// Per-pixel ball/obstacle collision detector: frame snapshot, side flags,
// first-contact capture and saturating hit count for ball_logic.
module ball_collision_detect
    import ball_collision_detect_pkg::*;
#(
    parameter int unsigned BALL_SIZE = BALL_SIZE_DEF,
    parameter int unsigned HIT_CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   nRst,
    ball_collision_detect_if.slave bus
);

    det_state_t state_q, state_d;

    logic [X_W-1:0]       snap_x;
    logic [Y_W-1:0]       snap_y;
    logic                 in_box, e_top, e_bottom, e_left, e_right;
    logic                 hit;

    logic                 pix_q, col_q, top_q, bot_q, left_q, right_q;
    logic                 fv_q;
    logic [X_W-1:0]       fx_q;
    logic [Y_W-1:0]       fy_q;
    logic [HIT_CNT_W-1:0] cnt_q;

    ball_box_match #(.BALL_SIZE(BALL_SIZE)) u_match (
        .snap_x     (snap_x),
        .snap_y     (snap_y),
        .hpos       (bus.hpos),
        .vpos       (bus.vpos),
        .active     (bus.active),
        .in_box     (in_box),
        .edge_top   (e_top),
        .edge_bottom(e_bottom),
        .edge_left  (e_left),
        .edge_right (e_right)
    );

    always_ff @(posedge clk) begin
        if (!nRst) state_q <= UNARMED;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        hit     = 1'b0;
        if (bus.frame_pulse) state_d = ARMED;
        if (state_q == ARMED) hit = in_box && bus.obstacle;
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            snap_x <= '0;
            snap_y <= '0;
        end else if (bus.frame_pulse) begin
            snap_x <= bus.ball_x;
            snap_y <= bus.ball_y;
        end
    end

    // The frame pulse wins over the pixel presented with it: that pixel is dropped.
    always_ff @(posedge clk) begin
        if (!nRst || bus.frame_pulse) begin
            pix_q   <= 1'b0;
            col_q   <= 1'b0;
            top_q   <= 1'b0;
            bot_q   <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            fv_q    <= 1'b0;
            fx_q    <= '0;
            fy_q    <= '0;
            cnt_q   <= '0;
        end else begin
            pix_q   <= (state_q == ARMED) && in_box;
            col_q   <= hit;
            top_q   <= hit && e_top;
            bot_q   <= hit && e_bottom;
            left_q  <= hit && e_left;
            right_q <= hit && e_right;
            if (hit && !fv_q) begin
                fv_q <= 1'b1;
                fx_q <= bus.hpos;
                fy_q <= bus.vpos;
            end
            if (hit && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.ball_pixel      = pix_q;
    assign bus.collision       = col_q;
    assign bus.ball_top_col    = top_q;
    assign bus.ball_bottom_col = bot_q;
    assign bus.ball_left_col   = left_q;
    assign bus.ball_right_col  = right_q;
    assign bus.first_hit_valid = fv_q;
    assign bus.first_hit_x     = fx_q;
    assign bus.first_hit_y     = fy_q;
    assign bus.hit_count       = cnt_q;

endmodule

// File: tb/tb_ball_collision_detect.sv
// Directed vector bench for ball_collision_detect (BALL_SIZE=4, HIT_CNT_W=4).
module tb_ball_collision_detect;

    logic clk;
    logic nRst;
    int   checks;
    int   failures;

    ball_collision_detect_if #(.HIT_CNT_W(4)) bus ();

    ball_collision_detect #(.BALL_SIZE(4), .HIT_CNT_W(4)) dut (
        .clk (clk),
        .nRst(nRst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fp;
        logic [9:0]  bx;
        logic [8:0]  by;
        logic [9:0]  h;
        logic [8:0]  v;
        logic        act;
        logic        obs;
        logic [29:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Packed expected/actual layout: pix,col,top,bottom,left,right,fv,fx,fy,cnt
    function automatic logic [29:0] e(logic pix, logic col, logic t, logic b, logic l, logic r,
                                      logic fv, int fx, int fy, int cnt);
        logic [9:0] x10;
        logic [8:0] y9;
        logic [3:0] c4;
        x10 = 10'(fx);
        y9  = 9'(fy);
        c4  = 4'(cnt);
        return {pix, col, t, b, l, r, fv, x10, y9, c4};
    endfunction

    function automatic vec_t mk(logic rst, logic fp, int bx, int by, int h, int v,
                                logic act, logic obs, logic [29:0] exp);
        vec_t r;
        r.rst = rst; r.fp = fp;
        r.bx = 10'(bx); r.by = 9'(by);
        r.h = 10'(h); r.v = 9'(v);
        r.act = act; r.obs = obs; r.exp = exp;
        return r;
    endfunction

    function automatic logic [29:0] actual();
        return {bus.ball_pixel, bus.collision, bus.ball_top_col, bus.ball_bottom_col,
                bus.ball_left_col, bus.ball_right_col, bus.first_hit_valid,
                bus.first_hit_x, bus.first_hit_y, bus.hit_count};
    endfunction

    task automatic apply(input vec_t vv, input string name);
        logic [29:0] got;
        @(negedge clk);
        nRst            = vv.rst;
        bus.frame_pulse = vv.fp;
        bus.ball_x      = vv.bx;
        bus.ball_y      = vv.by;
        bus.hpos        = vv.h;
        bus.vpos        = vv.v;
        bus.active      = vv.act;
        bus.obstacle    = vv.obs;
        @(posedge clk);
        #1;
        got = actual();
        checks++;
        if (got !== vv.exp) begin
            failures++;
            $display("FAIL %s: got pix=%b col=%b tblr=%b%b%b%b fv=%b fx=%0d fy=%0d cnt=%0d, expected pix=%b col=%b tblr=%b%b%b%b fv=%b fx=%0d fy=%0d cnt=%0d",
                     name, got[29], got[28], got[27], got[26], got[25], got[24], got[23],
                     got[22:13], got[12:4], got[3:0],
                     vv.exp[29], vv.exp[28], vv.exp[27], vv.exp[26], vv.exp[25], vv.exp[24],
                     vv.exp[23], vv.exp[22:13], vv.exp[12:4], vv.exp[3:0]);
        end
    endtask

    initial begin
        logic [29:0] z;
        int          n;
        checks   = 0;
        failures = 0;
        nRst            = 1'b0;
        bus.frame_pulse = 1'b0;
        bus.ball_x      = '0;
        bus.ball_y      = '0;
        bus.hpos        = '0;
        bus.vpos        = '0;
        bus.active      = 1'b0;
        bus.obstacle    = 1'b0;
        z = e(0,0,0,0,0,0, 0,0,0,0);

        // reset and pre-arm behaviour
        vecs.push_back(mk(0,0,100,200,100,200,1,1, z));
        vecs.push_back(mk(0,0,100,200,100,200,1,1, z));
        vecs.push_back(mk(1,0,100,200,100,200,1,1, z));
        vecs.push_back(mk(1,0,100,200,101,200,1,1, z));
        // arm with ball (100,200); pulse pixel is discarded
        vecs.push_back(mk(1,1,100,200,100,200,1,1, z));
        vecs.push_back(mk(1,0,100,200, 99,200,1,1, z));
        vecs.push_back(mk(1,0,100,200,100,200,1,1, e(1,1,1,0,1,0, 1,100,200,1)));
        vecs.push_back(mk(1,0,100,200,101,200,1,1, e(1,1,1,0,0,0, 1,100,200,2)));
        vecs.push_back(mk(1,0,100,200,102,200,1,1, e(1,1,1,0,0,0, 1,100,200,3)));
        vecs.push_back(mk(1,0,100,200,103,200,1,1, e(1,1,1,0,0,1, 1,100,200,4)));
        vecs.push_back(mk(1,0,100,200,104,200,1,1, e(0,0,0,0,0,0, 1,100,200,4)));
        // interior single hit
        vecs.push_back(mk(1,1,100,200,  0,  0,1,0, z));
        vecs.push_back(mk(1,0,100,200,102,201,1,0, e(1,0,0,0,0,0, 0,0,0,0)));
        vecs.push_back(mk(1,0,100,200,102,202,1,1, e(1,1,0,0,0,0, 1,102,202,1)));
        vecs.push_back(mk(1,0,100,200,103,203,1,0, e(1,0,0,0,0,0, 1,102,202,1)));
        vecs.push_back(mk(1,0,100,200,100,202,0,1, e(0,0,0,0,0,0, 1,102,202,1)));
        // ball_x moves without a pulse: old snapshot still used
        vecs.push_back(mk(1,0,300,200,300,200,1,1, e(0,0,0,0,0,0, 1,102,202,1)));
        vecs.push_back(mk(1,0,300,200,101,201,1,1, e(1,1,0,0,0,0, 1,102,202,2)));
        // ball at the screen corner, no wrap
        vecs.push_back(mk(1,1,638,476,  0,  0,1,0, z));
        vecs.push_back(mk(1,0,638,476,637,476,1,1, z));
        vecs.push_back(mk(1,0,638,476,638,476,1,1, e(1,1,1,0,1,0, 1,638,476,1)));
        vecs.push_back(mk(1,0,638,476,639,476,1,1, e(1,1,1,0,0,0, 1,638,476,2)));
        vecs.push_back(mk(1,0,638,476,  0,476,1,1, e(0,0,0,0,0,0, 1,638,476,2)));
        vecs.push_back(mk(1,0,638,476,  1,476,1,1, e(0,0,0,0,0,0, 1,638,476,2)));
        vecs.push_back(mk(1,0,638,476,639,479,1,1, e(1,1,0,1,0,0, 1,638,476,3)));
        // mid-frame reset disarms until the next pulse
        vecs.push_back(mk(0,0,638,476,639,479,1,1, z));
        vecs.push_back(mk(1,0,638,476,639,479,1,1, z));
        vecs.push_back(mk(1,1,100,200,  0,  0,1,0, z));
        vecs.push_back(mk(1,0,100,200,101,201,1,1, e(1,1,0,0,0,0, 1,101,201,1)));
        vecs.push_back(mk(1,0,100,200,103,203,1,1, e(1,1,0,1,0,1, 1,101,201,2)));

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("vec[%0d]", i));

        // saturation: 20 collision pixels on a fresh frame
        apply(mk(1,1,100,200,0,0,1,0, z), "sat_pulse");
        n = 0;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 4; c++) begin
                int row;
                logic t, b, l, r;
                row = 200 + (k % 4);
                n++;
                t = (row == 200);
                b = (row == 203);
                l = (c == 0);
                r = (c == 3);
                apply(mk(1,0,100,200,100+c,row,1,1,
                         e(1,1,t,b,l,r, 1,100,200,(n > 15) ? 15 : n)),
                      $sformatf("sat_px%0d", n));
            end
        end
        // pulse on an obstacle pixel clears everything and drops that pixel
        apply(mk(1,1,100,200,100,200,1,1, z), "pulse_on_hit");
        apply(mk(1,0,100,200,101,201,1,1, e(1,1,0,0,0,0, 1,101,201,1)), "after_pulse");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
